// File: rtl/mac_operand_sequencer_if.sv
// Operand-stream and result-port bundle for mac_operand_sequencer.
//   in_valid/in_ready/in_data/in_last : upstream operand pairs, [3:0]=a, [7:4]=b
//   out_valid/out_ready/out_data/out_count : final accumulator value and pair count
// master = host side (drives operands, accepts results); slave = sequencer.
interface mac_operand_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Operand-side driver for the 4x4 MAC: buffers a vector of up to DEPTH operand
// pairs, clears the MAC accumulator, issues one pair per cycle, then returns
// the final accumulator value with the pair count.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_if (slave)      : operand stream in, result port out
//   mac_a, mac_b      : operands to the MAC
//   mac_en, mac_clr   : MAC accumulate / clear strobes (clear has priority in the MAC)
//   mac_acc           : MAC accumulator register value
module mac_operand_sequencer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mac_operand_sequencer_if.slave s_if,
  output logic [3:0]            mac_a,
  output logic [3:0]            mac_b,
  output logic                  mac_en,
  output logic                  mac_clr,
  input  logic [7:0]            mac_acc
);
  localparam int unsigned PTR_W = 4;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_d;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_ridx;
  logic [PTR_W-1:0] w_ridx_d;
  logic             r_in_ready;
  logic             r_mac_en;
  logic             r_mac_clr;
  logic             r_out_valid;
  logic [3:0]       r_mac_a;
  logic [3:0]       r_mac_b;
  logic [7:0]       r_out_data;
  logic [3:0]       r_out_count;
  logic [7:0]       r_buf [DEPTH];
  logic             w_accept;
  logic             w_handshake;
  logic [7:0]       w_pair;

  // Next-state and transfer decode.
  always_comb begin
    w_state_d   = r_state;
    w_ridx_d    = r_ridx;
    w_accept    = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_accept = s_if.in_valid;
        // Filling the last buffer entry ends the vector even without in_last.
        if (w_accept && (s_if.in_last || (r_wptr == LAST_IDX))) begin
          w_state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_state_d = S_RUN;
        w_ridx_d  = '0;
      end
      S_RUN: begin
        if (r_ridx == PTR_W'(r_out_count - 4'd1)) begin
          w_state_d = S_WAIT;
        end else begin
          w_ridx_d = PTR_W'(r_ridx + 1'b1);
        end
      end
      S_WAIT: begin
        w_state_d = S_RESULT;
      end
      S_RESULT: begin
        w_handshake = s_if.out_ready;
        if (w_handshake) begin
          w_state_d = S_LOAD;
        end
      end
      default: begin
        w_state_d = S_LOAD;
      end
    endcase
  end

  // Pair to be issued in the next cycle when entering/staying in RUN.
  assign w_pair = r_buf[w_ridx_d[IDX_W-1:0]];

  // State and registered outputs; strobes decoded from the next state so they
  // line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_wptr      <= '0;
      r_ridx      <= '0;
      r_in_ready  <= 1'b1;
      r_mac_en    <= 1'b0;
      r_mac_clr   <= 1'b0;
      r_out_valid <= 1'b0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else begin
      r_state     <= w_state_d;
      r_ridx      <= w_ridx_d;
      r_in_ready  <= (w_state_d == S_LOAD);
      r_mac_clr   <= (w_state_d == S_CLEAR);
      r_mac_en    <= (w_state_d == S_RUN);
      r_out_valid <= (w_state_d == S_RESULT);
      if (w_handshake) begin
        r_wptr <= '0;
      end else if (w_accept) begin
        r_wptr <= PTR_W'(r_wptr + 1'b1);
      end
      if (r_state == S_CLEAR) begin
        r_out_count <= r_wptr;
      end
      if (w_state_d == S_RUN) begin
        r_mac_a <= w_pair[3:0];
        r_mac_b <= w_pair[7:4];
      end
      // mac_acc already holds the final sum during WAIT.
      if (r_state == S_WAIT) begin
        r_out_data <= mac_acc;
      end
    end
  end

  // Operand buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_wptr[IDX_W-1:0]] <= s_if.in_data;
    end
  end

  assign s_if.in_ready  = r_in_ready;
  assign s_if.out_valid = r_out_valid;
  assign s_if.out_data  = r_out_data;
  assign s_if.out_count = r_out_count;
  assign mac_a          = r_mac_a;
  assign mac_b          = r_mac_b;
  assign mac_en         = r_mac_en;
  assign mac_clr        = r_mac_clr;
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: stand-in MAC core, timeline-based reference
// model checked every cycle, directed vectors with literal results, then a
// randomized stream with random backpressure and one mid-stream reset.
module tb_mac_operand_sequencer;
  localparam int unsigned DEPTH = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] mac_a;
  logic [3:0] mac_b;
  logic       mac_en;
  logic       mac_clr;
  logic [7:0] mac_acc;

  mac_operand_sequencer_if h();

  mac_operand_sequencer #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_if   (h),
    .mac_a  (mac_a),
    .mac_b  (mac_b),
    .mac_en (mac_en),
    .mac_clr(mac_clr),
    .mac_acc(mac_acc)
  );

  always #5 clk = ~clk;

  // MAC core stand-in: clear wins over accumulate, sum wraps at 8 bits.
  logic [7:0] acc = 8'h00;
  always @(posedge clk) begin
    if (mac_clr)     acc <= 8'h00;
    else if (mac_en) acc <= acc + 8'(mac_a) * 8'(mac_b);
  end
  assign mac_acc = acc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no response within bound (t=%0t)", nm, $time);
  endtask

  // Reference model: a vector completes at edge T; its timeline is then fixed:
  // clear in the cycle after T, n issue cycles, one wait cycle, then result
  // until a handshake. Cycle index = number of edges seen so far.
  int         cyc = 0;
  bit         m_busy = 1'b0;
  int         m_t = 0;
  int         m_n = 0;
  logic [7:0] m_load[$];
  logic [7:0] m_vec[$];
  logic [7:0] m_sum = 8'h00;
  logic [3:0] m_last_a = 4'h0;
  logic [3:0] m_last_b = 4'h0;
  int         m_results = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_load.delete();
    end else if (m_busy) begin
      if ((cyc >= m_t + m_n + 2) && h.out_ready) begin
        m_busy = 1'b0;
        m_results++;
      end
    end else if (h.in_valid) begin
      m_load.push_back(h.in_data);
      if (h.in_last || (m_load.size() == DEPTH)) begin
        int s;
        m_vec = m_load;
        m_load.delete();
        m_n    = m_vec.size();
        m_t    = cyc + 1;
        m_busy = 1'b1;
        s = 0;
        foreach (m_vec[i]) s += int'(m_vec[i][3:0]) * int'(m_vec[i][7:4]);
        m_sum = 8'(s % 256);
      end
    end
    cyc++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit en_x;
    bit clr_x;
    bit val_x;
    if (!rst_n) begin
      chk("rst_in_ready", 32'(h.in_ready), 32'd1);
      chk("rst_mac_en", 32'(mac_en), 32'd0);
      chk("rst_mac_clr", 32'(mac_clr), 32'd0);
      chk("rst_out_valid", 32'(h.out_valid), 32'd0);
      chk("rst_out_data", 32'(h.out_data), 32'd0);
      chk("rst_out_count", 32'(h.out_count), 32'd0);
      chk("rst_mac_a", 32'(mac_a), 32'd0);
      chk("rst_mac_b", 32'(mac_b), 32'd0);
      m_last_a = 4'h0;
      m_last_b = 4'h0;
    end else begin
      clr_x = m_busy && (cyc == m_t);
      en_x  = m_busy && (cyc >= m_t + 1) && (cyc <= m_t + m_n);
      val_x = m_busy && (cyc >= m_t + m_n + 2);
      if (en_x) begin
        m_last_a = m_vec[cyc - m_t - 1][3:0];
        m_last_b = m_vec[cyc - m_t - 1][7:4];
      end
      chk("in_ready", 32'(h.in_ready), 32'(!m_busy));
      chk("mac_clr", 32'(mac_clr), 32'(clr_x));
      chk("mac_en", 32'(mac_en), 32'(en_x));
      chk("out_valid", 32'(h.out_valid), 32'(val_x));
      chk("mac_a", 32'(mac_a), 32'(m_last_a));
      chk("mac_b", 32'(mac_b), 32'(m_last_b));
      if (val_x) begin
        chk("out_data", 32'(h.out_data), 32'(m_sum));
        chk("out_count", 32'(h.out_count), 32'(m_n));
      end
    end
  end

  // Present one pair and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic last);
    bit rdy;
    int waitc;
    rdy   = 1'b0;
    waitc = 0;
    h.in_valid = 1'b1;
    h.in_data  = d;
    h.in_last  = last;
    while (!rdy) begin
      @(negedge clk);
      rdy = h.in_ready;
      @(posedge clk);
      #1;
      waitc++;
      if (!rdy && waitc > 200) begin
        timeout_fail("send_timeout");
        break;
      end
    end
    h.in_valid = 1'b0;
    h.in_last  = 1'b0;
  endtask

  // Count sampled cycles until out_valid; in_ready must stay low meanwhile.
  task automatic wait_result(output logic [7:0] d, output logic [3:0] c, output int k);
    k = 0;
    d = 8'h00;
    c = 4'h0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      chk("busy_in_ready", 32'(h.in_ready), 32'd0);
      if (h.out_valid) begin
        k = i;
        d = h.out_data;
        c = h.out_count;
        break;
      end
    end
    if (k == 0) timeout_fail("result_timeout");
  endtask

  logic [7:0] basic [3];
  logic [7:0] rd;
  logic [3:0] rc;
  int         rk;
  int         r0;

  initial begin
    h.in_valid  = 1'b0;
    h.in_data   = 8'h00;
    h.in_last   = 1'b0;
    h.out_ready = 1'b1;
    basic[0] = 8'h53;
    basic[1] = 8'h72;
    basic[2] = 8'hFF;

    // Reset with in_valid asserted: nothing may be written.
    h.in_valid = 1'b1;
    h.in_data  = 8'hAB;
    h.in_last  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 32'(h.in_ready), 32'd1);
    chk("reset_out_valid", 32'(h.out_valid), 32'd0);
    chk("reset_out_data", 32'(h.out_data), 32'h00);
    h.in_valid = 1'b0;
    h.in_last  = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic vector (3,5),(2,7),(15,15) with a cycle-by-cycle literal timeline.
    send(basic[0], 1'b0);
    send(basic[1], 1'b0);
    send(basic[2], 1'b1);
    @(negedge clk);
    chk("basic_clr_t1", 32'(mac_clr), 32'd1);
    chk("basic_en_t1", 32'(mac_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("basic_en", 32'(mac_en), 32'd1);
      chk("basic_pair", 32'({mac_b, mac_a}), 32'(basic[i]));
    end
    @(negedge clk);
    chk("basic_wait_en", 32'(mac_en), 32'd0);
    chk("basic_wait_valid", 32'(h.out_valid), 32'd0);
    @(negedge clk);
    chk("basic_valid_t6", 32'(h.out_valid), 32'd1);
    chk("basic_data", 32'(h.out_data), 32'hFE);
    chk("basic_count", 32'(h.out_count), 32'd3);
    @(negedge clk);
    chk("basic_valid_drop", 32'(h.out_valid), 32'd0);
    chk("basic_ready_back", 32'(h.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Wrap: 2 * 225 = 450 -> 0xC2.
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    wait_result(rd, rc, rk);
    chk("wrap_data", 32'(rd), 32'hC2);
    chk("wrap_count", 32'(rc), 32'd2);
    chk("wrap_latency", 32'(rk), 32'd5);
    @(posedge clk);
    #1;

    // Forced last: 8 pairs of (1,1) without in_last, 9th pair held waiting.
    for (int i = 0; i < 8; i++) send(8'h11, 1'b0);
    h.in_valid = 1'b1;
    h.in_data  = 8'h22;
    h.in_last  = 1'b1;
    @(negedge clk);
    chk("forced_ready_drop", 32'(h.in_ready), 32'd0);
    wait_result(rd, rc, rk);
    chk("forced_data", 32'(rd), 32'h08);
    chk("forced_count", 32'(rc), 32'd8);
    chk("forced_latency", 32'(rk), 32'd10);
    @(negedge clk);
    chk("forced_ready_after_hs", 32'(h.in_ready), 32'd1);
    @(posedge clk);
    #1;
    h.in_valid = 1'b0;
    h.in_last  = 1'b0;
    wait_result(rd, rc, rk);
    chk("ninth_data", 32'(rd), 32'h04);
    chk("ninth_count", 32'(rc), 32'd1);
    chk("ninth_latency", 32'(rk), 32'd4);
    @(posedge clk);
    #1;

    // Backpressure: (2,3),(4,5) -> 26, result held for 5 stalled cycles.
    h.out_ready = 1'b0;
    send(8'h32, 1'b0);
    send(8'h54, 1'b1);
    wait_result(rd, rc, rk);
    chk("bp_data", 32'(rd), 32'h1A);
    chk("bp_count", 32'(rc), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_hold_valid", 32'(h.out_valid), 32'd1);
      chk("bp_hold_data", 32'(h.out_data), 32'h1A);
      chk("bp_hold_ready", 32'(h.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    h.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", 32'(h.out_valid), 32'd1);
    @(negedge clk);
    chk("bp_after_valid", 32'(h.out_valid), 32'd0);
    chk("bp_after_ready", 32'(h.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Reset during the second issue cycle.
    send(8'h21, 1'b0);
    send(8'h43, 1'b0);
    send(8'h65, 1'b1);
    repeat (3) @(negedge clk);
    chk("midrst_en_before", 32'(mac_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_en_async", 32'(mac_en), 32'd0);
    chk("midrst_clr_async", 32'(mac_clr), 32'd0);
    chk("midrst_valid", 32'(h.out_valid), 32'd0);
    chk("midrst_ready", 32'(h.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_valid", 32'(h.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(8'h44, 1'b1);
    wait_result(rd, rc, rk);
    chk("postrst_data", 32'(rd), 32'h10);
    chk("postrst_count", 32'(rc), 32'd1);
    chk("postrst_latency", 32'(rk), 32'd4);
    @(posedge clk);
    #1;

    // Random stream with random backpressure and one reset pulse.
    r0 = m_results;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      h.in_valid  = ($urandom_range(0, 3) != 0);
      h.in_data   = 8'($urandom);
      h.in_last   = ($urandom_range(0, 4) == 0);
      h.out_ready = ($urandom_range(0, 3) != 0);
      if (i == 1500) rst_n = 1'b0;
      if (i == 1503) rst_n = 1'b1;
    end
    @(posedge clk);
    #1;
    h.in_valid  = 1'b0;
    h.in_last   = 1'b0;
    h.out_ready = 1'b1;
    repeat (30) @(posedge clk);
    chk("rand_vectors_done", 32'(m_results - r0 > 20), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
